// File: rtl/tlb_port_arbiter.sv
// ============================================================================
// Module   : tlb_port_arbiter
// Purpose  : Round-robin arbiter sharing one TLB lookup port between the
//            instruction-fetch and data requesters. Optional watchdog is
//            enabled by defining TLB_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tlb_port_arbiter #(
   parameter int VADDR_W = 32,
   parameter int PADDR_W = 32
) (
   input  logic               clk,
   input  logic               resetn,
   input  logic               i_req,
   input  logic [VADDR_W-1:0] i_vaddr,
   input  logic               d_req,
   input  logic [VADDR_W-1:0] d_vaddr,
   input  logic               d_write,
   output logic               i_ready,
   output logic               d_ready,
   output logic               i_resp_valid,
   output logic [PADDR_W-1:0] i_paddr,
   output logic               i_fault,
   output logic               d_resp_valid,
   output logic [PADDR_W-1:0] d_paddr,
   output logic               d_fault,
   output logic               tlb_req,
   output logic [VADDR_W-1:0] tlb_vaddr,
   output logic               tlb_write,
   input  logic               tlb_ready,
   input  logic               tlb_resp_valid,
   input  logic [PADDR_W-1:0] tlb_paddr,
   input  logic               tlb_fault,
   input  logic               op_busy
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2
   } state_t;

   localparam logic c_OWN_I = 1'b0;
   localparam logic c_OWN_D = 1'b1;

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_owner;
   logic                 r_last_grant;
   logic [VADDR_W-1:0]   r_lat_vaddr;
   logic                 r_lat_write;
   logic                 w_grant_i;
   logic                 w_grant_d;
   logic                 w_done;
   logic                 w_wdog_hit;
   logic [PADDR_W-1:0]   w_rsp_paddr;
   logic                 w_rsp_fault;

`ifdef TLB_ARB_TIMEOUT_EN
   logic [7:0] r_wdog;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_wdog <= 8'd0;
      end else if (w_grant_i || w_grant_d) begin
         r_wdog <= 8'd0;
      end else if (r_state != S_IDLE) begin
         r_wdog <= r_wdog + 8'd1;
      end
   end

   assign w_wdog_hit = (r_state != S_IDLE) && (r_wdog == 8'hFF) && !tlb_resp_valid;
`else
   assign w_wdog_hit = 1'b0;
`endif

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Grants are gated by resetn so no ready pulse escapes while reset is held.
   always_comb begin
      w_state_nxt = r_state;
      w_grant_i   = 1'b0;
      w_grant_d   = 1'b0;
      w_done      = 1'b0;
      tlb_req     = 1'b0;
      tlb_vaddr   = '0;
      tlb_write   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (resetn && !op_busy) begin
               if (d_req && (!i_req || (r_last_grant == c_OWN_I))) begin
                  w_grant_d = 1'b1;
               end else if (i_req) begin
                  w_grant_i = 1'b1;
               end
               if (i_req || d_req) begin
                  w_state_nxt = S_ISSUE;
               end
            end
         end
         S_ISSUE: begin
            tlb_req   = 1'b1;
            tlb_vaddr = r_lat_vaddr;
            tlb_write = r_lat_write;
            if (tlb_resp_valid || w_wdog_hit) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end else if (tlb_ready) begin
               w_state_nxt = S_WAIT;
            end
         end
         S_WAIT: begin
            if (tlb_resp_valid || w_wdog_hit) begin
               w_done      = 1'b1;
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_owner      <= c_OWN_I;
         r_last_grant <= c_OWN_I;
         r_lat_vaddr  <= '0;
         r_lat_write  <= 1'b0;
      end else begin
         if (w_grant_d) begin
            r_owner     <= c_OWN_D;
            r_lat_vaddr <= d_vaddr;
            r_lat_write <= d_write;
         end else if (w_grant_i) begin
            r_owner     <= c_OWN_I;
            r_lat_vaddr <= i_vaddr;
            r_lat_write <= 1'b0;
         end
         if (w_done) begin
            r_last_grant <= r_owner;
         end
      end
   end

   // A watchdog completion reports a fault with a zero address.
   assign w_rsp_paddr  = tlb_resp_valid ? tlb_paddr : '0;
   assign w_rsp_fault  = tlb_resp_valid ? tlb_fault : 1'b1;

   assign i_ready      = w_grant_i;
   assign d_ready      = w_grant_d;
   assign i_resp_valid = w_done && (r_owner == c_OWN_I);
   assign d_resp_valid = w_done && (r_owner == c_OWN_D);
   assign i_paddr      = i_resp_valid ? w_rsp_paddr : '0;
   assign d_paddr      = d_resp_valid ? w_rsp_paddr : '0;
   assign i_fault      = i_resp_valid && w_rsp_fault;
   assign d_fault      = d_resp_valid && w_rsp_fault;

endmodule

`default_nettype wire

// File: tb/tb_tlb_port_arbiter.sv
// ============================================================================
// Module   : tb_tlb_port_arbiter
// Purpose  : Directed and randomized bench for tlb_port_arbiter against a
//            transaction-level reference model (honours TLB_ARB_TIMEOUT_EN).
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_tlb_port_arbiter;

   logic        clk;
   logic        resetn;
   logic        i_req, d_req, d_write;
   logic [31:0] i_vaddr, d_vaddr;
   logic        i_ready, d_ready, i_resp_valid, d_resp_valid, i_fault, d_fault;
   logic [31:0] i_paddr, d_paddr;
   logic        tlb_req, tlb_write;
   logic [31:0] tlb_vaddr;
   logic        tlb_ready, tlb_resp_valid, tlb_fault, op_busy;
   logic [31:0] tlb_paddr;

   tlb_port_arbiter #(.VADDR_W(32), .PADDR_W(32)) u_dut (
      .clk            (clk),
      .resetn         (resetn),
      .i_req          (i_req),
      .i_vaddr        (i_vaddr),
      .d_req          (d_req),
      .d_vaddr        (d_vaddr),
      .d_write        (d_write),
      .i_ready        (i_ready),
      .d_ready        (d_ready),
      .i_resp_valid   (i_resp_valid),
      .i_paddr        (i_paddr),
      .i_fault        (i_fault),
      .d_resp_valid   (d_resp_valid),
      .d_paddr        (d_paddr),
      .d_fault        (d_fault),
      .tlb_req        (tlb_req),
      .tlb_vaddr      (tlb_vaddr),
      .tlb_write      (tlb_write),
      .tlb_ready      (tlb_ready),
      .tlb_resp_valid (tlb_resp_valid),
      .tlb_paddr      (tlb_paddr),
      .tlb_fault      (tlb_fault),
      .op_busy        (op_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   // One outstanding transaction: who owns it, what it looks up, whether
   // the TLB has taken the request, and how long it has been in flight.
   bit          m_valid, m_sent, m_owner_d, m_last_d, m_write;
   logic [31:0] m_vaddr;
   int          m_age;
   bit          g_i, g_d, o_gi, o_gd, o_dv;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_valid   = 0;
      m_sent    = 0;
      m_owner_d = 0;
      m_last_d  = 0;
      m_write   = 0;
      m_vaddr   = '0;
      m_age     = 0;
   endtask

   task automatic step();
      bit          e_gi, e_gd, e_tr, tout, done;
      logic [31:0] e_tv, e_p;
      bit          e_f;
      #1;
      e_gi = 0;
      e_gd = 0;
      if (!m_valid && !op_busy) begin
         if (i_req && d_req) begin
            e_gd = !m_last_d;
            e_gi = m_last_d;
         end else begin
            e_gi = i_req;
            e_gd = d_req;
         end
      end
      e_tr = m_valid && !m_sent;
      e_tv = e_tr ? m_vaddr : 32'h0;
      tout = 0;
`ifdef TLB_ARB_TIMEOUT_EN
      tout = m_valid && !tlb_resp_valid && (m_age == 255);
`endif
      done = m_valid && (tlb_resp_valid || tout);
      e_p  = tlb_resp_valid ? tlb_paddr : 32'h0;
      e_f  = tlb_resp_valid ? tlb_fault : 1'b1;
      chk("i_ready", i_ready, e_gi);
      chk("d_ready", d_ready, e_gd);
      chk("tlb_req", tlb_req, e_tr);
      chk("tlb_vaddr", tlb_vaddr, e_tv);
      chk("tlb_write", tlb_write, e_tr && m_write);
      chk("i_resp_valid", i_resp_valid, done && !m_owner_d);
      chk("d_resp_valid", d_resp_valid, done && m_owner_d);
      chk("i_paddr", i_paddr, (done && !m_owner_d) ? e_p : 32'h0);
      chk("d_paddr", d_paddr, (done && m_owner_d) ? e_p : 32'h0);
      chk("i_fault", i_fault, done && !m_owner_d && e_f);
      chk("d_fault", d_fault, done && m_owner_d && e_f);
      g_i  = e_gi;
      g_d  = e_gd;
      o_gi = i_ready;
      o_gd = d_ready;
      o_dv = d_resp_valid;
      if (done) begin
         m_valid  = 0;
         m_last_d = m_owner_d;
      end else if (m_valid) begin
         if (tlb_ready) m_sent = 1;
         m_age++;
      end
      if (e_gi || e_gd) begin
         m_valid   = 1;
         m_sent    = 0;
         m_owner_d = e_gd;
         m_vaddr   = e_gd ? d_vaddr : i_vaddr;
         m_write   = e_gd && d_write;
         m_age     = 0;
      end
      @(posedge clk);
      #1;
   endtask

   // Asserted mid-cycle so the asynchronous clear is observed before any edge.
   task automatic do_reset();
      resetn = 1'b0;
      #1;
      chk("rst_ctl", {i_ready, d_ready, i_resp_valid, d_resp_valid,
                      tlb_req, tlb_write, i_fault, d_fault}, 64'h0);
      chk("rst_i_paddr", i_paddr, 64'h0);
      chk("rst_d_paddr", d_paddr, 64'h0);
      chk("rst_tlb_vaddr", tlb_vaddr, 64'h0);
      model_reset();
      @(posedge clk);
      #1;
      resetn = 1'b1;
   endtask

   task automatic idle_inputs();
      i_req = 0; d_req = 0; d_write = 0; op_busy = 0;
      tlb_ready = 0; tlb_resp_valid = 0; tlb_fault = 0; tlb_paddr = '0;
   endtask

   initial begin
      logic [3:0] ord;
      int         cnt;
      resetn  = 1'b0;
      i_vaddr = '0;
      d_vaddr = '0;
      idle_inputs();
      @(posedge clk);
      #1;
      i_req = 1; d_req = 1; tlb_resp_valid = 1;
      do_reset();
      idle_inputs();

      // Single fetch request with a one-cycle TLB.
      i_req = 1; i_vaddr = 32'h8000_1000;
      step();
      chk("r030_ready", o_gi, 1'b1);
      i_req = 0; tlb_ready = 1; tlb_resp_valid = 1; tlb_paddr = 32'h0000_1000;
      #1;
      chk("r030_valid", i_resp_valid, 1'b1);
      chk("r030_paddr", i_paddr, 32'h0000_1000);
      step();
      idle_inputs();

      // Both requesters held: alternating grants starting with data.
      i_req = 1; d_req = 1; tlb_resp_valid = 1;
      do_reset();
      tlb_ready = 1; tlb_resp_valid = 1; i_vaddr = 32'h1111_0000; d_vaddr = 32'h2222_0000;
      ord = '0;
      cnt = 0;
      for (int k = 0; k < 8; k++) begin
         step();
         if (o_gi || o_gd) begin
            ord = {ord[2:0], o_gd};
            cnt++;
         end
      end
      chk("rr_count", cnt, 4);
      chk("rr_order", ord, 4'b1010);
      idle_inputs();
      step();

      // op_busy holds off a pending data request.
      d_req = 1; op_busy = 1; d_vaddr = 32'h3333_3000;
      cnt = 0;
      for (int k = 0; k < 5; k++) begin
         step();
         if (o_gd) cnt++;
      end
      chk("busy_block", cnt, 0);
      op_busy = 0;
      step();
      chk("busy_release", o_gd, 1'b1);
      d_req = 0; tlb_resp_valid = 1;
      step();
      idle_inputs();

      // Store with a late faulting response.
      d_req = 1; d_write = 1; d_vaddr = 32'h4444_4000;
      step();
      d_req = 0; d_write = 0; tlb_ready = 1;
      #1;
      chk("st_tlb_write", tlb_write, 1'b1);
      step();
      tlb_ready = 0;
      step();
      step();
      tlb_resp_valid = 1; tlb_fault = 1; tlb_paddr = 32'h0BAD_0000;
      #1;
      chk("st_d_fault", d_fault, 1'b1);
      chk("st_i_valid", i_resp_valid, 1'b0);
      step();
      idle_inputs();

      // Reset while waiting drops the transaction.
      d_req = 1; d_vaddr = 32'h5555_5000;
      step();
      d_req = 0; tlb_ready = 1;
      step();
      tlb_ready = 0;
      step();
      tlb_resp_valid = 1; tlb_paddr = 32'h0000_5000;
      do_reset();
      step();
      step();
      idle_inputs();

      // TLB accepts but never answers.
      d_req = 1; d_vaddr = 32'h6666_6000;
      step();
      d_req = 0; tlb_ready = 1;
      cnt = 0;
      for (int k = 0; k < 300; k++) begin
         step();
         tlb_ready = 0;
         if (o_dv) cnt++;
      end
`ifdef TLB_ARB_TIMEOUT_EN
      chk("wdog_pulses", cnt, 1);
`else
      chk("wdog_pulses", cnt, 0);
`endif
      tlb_resp_valid = 1;
      step();
      idle_inputs();

      // Randomized traffic with requesters holding until accepted.
      for (int k = 0; k < 4000; k++) begin
         op_busy        = ($urandom_range(0, 4) == 0);
         tlb_ready      = $urandom_range(0, 1);
         tlb_resp_valid = ($urandom_range(0, 2) == 0);
         tlb_paddr      = $urandom;
         tlb_fault      = ($urandom_range(0, 3) == 0);
         step();
         if (g_i) i_req = 0;
         if (g_d) d_req = 0;
         if (!i_req && $urandom_range(0, 2) == 0) begin
            i_req = 1; i_vaddr = $urandom;
         end
         if (!d_req && $urandom_range(0, 2) == 0) begin
            d_req = 1; d_vaddr = $urandom; d_write = $urandom_range(0, 1);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/tlb_port_arbiter.md
TLB_PORT_ARBITER -- requirements
Module: tlb_port_arbiter

Interface
REQ-001 SHALL have parameter VADDR_W, default 32, virtual address width.
REQ-002 SHALL have parameter PADDR_W, default 32, physical address width.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports i_req/d_req  input  1 each  fetch/data translation request, held until accepted.
REQ-006 SHALL have ports i_vaddr/d_vaddr  input  VADDR_W each  request address, stable while req is high.
REQ-007 SHALL have port d_write  input  1  data access is a store.
REQ-008 SHALL have ports i_ready/d_ready  output  1 each  one-cycle accept pulse.
REQ-009 SHALL have ports i_resp_valid/d_resp_valid  output  1 each  one-cycle response pulse.
REQ-010 SHALL have ports i_paddr/d_paddr  output  PADDR_W each; i_fault/d_fault  output  1 each.
REQ-011 SHALL have ports tlb_req  output  1; tlb_vaddr  output  VADDR_W; tlb_write  output  1  shared lookup port request.
REQ-012 SHALL have ports tlb_ready  input  1; tlb_resp_valid  input  1; tlb_paddr  input  PADDR_W; tlb_fault  input  1.
REQ-013 SHALL have port op_busy  input  1  TLB maintenance in progress; blocks new grants.

Function
REQ-014 SHALL implement FSM IDLE, ISSUE, WAIT plus registers owner (I/D), last_grant (I/D), lat_vaddr, lat_write.
REQ-015 IDLE, op_busy=0, any req: SHALL latch winner's vaddr/write, pulse winner's *_ready same cycle, set owner, go ISSUE.
REQ-016 Both requests in IDLE: SHALL grant the requester that is not last_grant (round-robin); single request granted directly.
REQ-017 IDLE with op_busy=1: SHALL grant nothing, no *_ready pulse, remain IDLE.
REQ-018 ISSUE: SHALL drive tlb_req=1, tlb_vaddr=lat_vaddr, tlb_write=lat_write; leave on tlb_ready=1.
REQ-019 ISSUE, tlb_ready=1, tlb_resp_valid=0: SHALL go WAIT; tlb_req=0 in WAIT.
REQ-020 ISSUE or WAIT with tlb_resp_valid=1 (incl. same cycle as tlb_ready): SHALL route tlb_paddr/tlb_fault to owner's *_paddr/*_fault, pulse owner's *_resp_valid combinationally that cycle, update last_grant=owner, go IDLE.
REQ-021 Non-owner *_resp_valid SHALL be 0 at all times; *_paddr/*_fault are don't-care when *_resp_valid=0, driven 0 in the reference design.
REQ-022 Minimum latency: accept at cycle N, tlb_req at N+1, response earliest at N+1; next grant earliest at N+2.
REQ-023 op_busy rising in ISSUE/WAIT SHALL NOT abort the transaction in flight.
REQ-024 tlb_resp_valid while IDLE SHALL be ignored (no response pulse).
REQ-025 At most one transaction outstanding; requests arriving in ISSUE/WAIT wait in IDLE arbitration.

Reset
REQ-026 resetn=0 SHALL asynchronously force IDLE, owner=I, last_grant=I (data wins first tie), lat_vaddr=0, lat_write=0.
REQ-027 During reset all outputs SHALL be 0; an in-flight transaction is dropped with no response; first grant possible cycle after resetn deasserts.

Configuration
REQ-028 Macro TLB_ARB_TIMEOUT_EN defined: SHALL include an 8-bit watchdog, cleared on ISSUE entry, incremented each ISSUE/WAIT cycle; at value 255 with no tlb_resp_valid, SHALL pulse owner's *_resp_valid with *_fault=1, *_paddr=0, go IDLE.
REQ-029 Macro TLB_ARB_TIMEOUT_EN undefined: SHALL omit the watchdog; FSM waits indefinitely in ISSUE/WAIT.

Verification
REQ-030 Only i_req, i_vaddr=0x8000_1000, tlb_ready and tlb_resp_valid=1 at N+1, tlb_paddr=0x0000_1000 -> i_ready at N, i_resp_valid, i_paddr=0x0000_1000 at N+1.
REQ-031 i_req and d_req both high from reset, tlb responds in 1 cycle -> grant order D, I, D, I; no requester starves.
REQ-032 op_busy=1 for 5 cycles with d_req=1 -> no d_ready for 5 cycles; grant on first cycle op_busy=0.
REQ-033 d_req, d_write=1, tlb_ready at N+1, tlb_resp_valid at N+4 with tlb_fault=1 -> tlb_write=1 in ISSUE, d_resp_valid and d_fault=1 at N+4, i_resp_valid stays 0.
REQ-034 resetn pulsed low during WAIT -> outputs 0 immediately, no response pulse, IDLE after release; later stray tlb_resp_valid ignored.
REQ-035 With TLB_ARB_TIMEOUT_EN, tlb_ready=1 but tlb_resp_valid never -> fault response pulse exactly at watchdog=255; without it, FSM remains in WAIT.
